// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types and constants for the elevator sequencing controller.
//   state_e      : controller states (IDLE, MOVE_UP, MOVE_DOWN, DOOR)
//   dir_e        : remembered sweep direction (UP, DOWN)
//   DEF_*        : default floor count and phase durations
//   timer_width(): width of the shared phase timer
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  localparam int DEF_N_FLOORS   = 10;
  localparam int DEF_TRAVEL_CYC = 8;
  localparam int DEF_DOOR_CYC   = 4;

  // Enough bits to hold the longer of the two phase reload values.
  function automatic int timer_width(input int travel_cyc, input int door_cyc);
    int longest;
    longest = (travel_cyc > door_cyc) ? travel_cyc : door_cyc;
    return $clog2(longest) + 32'sd1;
  endfunction

endpackage

// File: rtl/elevator_sched_if.sv
// elevator_sched_if: request/command bundle between the controller and the car.
//   button_out, button_in : hall and cab request buttons (into the controller)
//   current_floor         : one-hot car position
//   up, down, open        : motion and door commands
//   pending, busy         : outstanding requests and activity flag
// master = controller side, slave = button panel / car datapath side.
interface elevator_sched_if
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS
) ();

  logic [N_FLOORS-1:0] button_out;
  logic [N_FLOORS-1:0] button_in;
  logic [N_FLOORS-1:0] current_floor;
  logic [N_FLOORS-1:0] pending;
  logic                up;
  logic                down;
  logic                open;
  logic                busy;

  modport master (
    input  button_out, button_in,
    output current_floor, pending, up, down, open, busy
  );

  modport slave (
    output button_out, button_in,
    input  current_floor, pending, up, down, open, busy
  );

endinterface

// File: rtl/elev_timer.sv
// elev_timer: loadable down-counter shared by the travel and door phases.
//   clk, rst_n : clock and synchronous active-low reset
//   load       : reload strobe, takes priority over counting
//   load_val   : value loaded on load (phase length minus one)
//   done       : counter is at zero, i.e. the current cycle is the last one
module elev_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, else decrement and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/elevator_sched.sv
// elevator_sched: SCAN-policy sequencing controller for the elevator car.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : elevator_sched_if.master (buttons in; floor, up/down/open,
//                pending and busy out, all registered)
module elevator_sched
  import elevator_pkg::*;
#(
  parameter int N_FLOORS   = DEF_N_FLOORS,
  parameter int TRAVEL_CYC = DEF_TRAVEL_CYC,
  parameter int DOOR_CYC   = DEF_DOOR_CYC
) (
  input logic               clk,
  input logic               rst_n,
  elevator_sched_if.master  bus
);

  localparam int TMR_W = timer_width(TRAVEL_CYC, DOOR_CYC);
  // The timer counts down to zero inclusive, so load one less than the phase length.
  localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_CYC - 32'sd1);
  localparam logic [TMR_W-1:0] DOOR_LD   = TMR_W'(DOOR_CYC - 32'sd1);

  typedef logic [N_FLOORS-1:0] fvec_t;

  // Bits strictly above / below a one-hot floor.
  function automatic fvec_t mask_above(input fvec_t f);
    return ~(f | (f - N_FLOORS'(1'b1)));
  endfunction

  function automatic fvec_t mask_below(input fvec_t f);
    return f - N_FLOORS'(1'b1);
  endfunction

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  fvec_t      floor_q, floor_d;
  fvec_t      pending_q, pending_d;
  logic       up_q, down_q, open_q, busy_q;

  fvec_t      press_s, clr_s, ahead_s, behind_s;
  logic       req_here_s, req_above_s, req_below_s;
  logic       going_up_s, door_restart_s;
  logic       tmr_load_s, tmr_done_s;
  logic [TMR_W-1:0] tmr_val_s;

  assign press_s     = bus.button_out | bus.button_in;
  assign req_here_s  = |(pending_q & floor_q);
  assign req_above_s = |(pending_q & mask_above(floor_q));
  assign req_below_s = |(pending_q & mask_below(floor_q));
  assign going_up_s  = (state_q == MOVE_UP);

  elev_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // Next-state, floor, pending and timer control.
  always_comb begin
    state_d        = state_q;
    floor_d        = floor_q;
    door_restart_s = 1'b0;
    ahead_s        = '0;
    behind_s       = '0;
    case (state_q)
      IDLE: begin
        if (req_here_s) begin
          state_d = DOOR;
        end else if (req_above_s && req_below_s) begin
          state_d = (dir_q == UP) ? MOVE_UP : MOVE_DOWN;
        end else if (req_above_s) begin
          state_d = MOVE_UP;
        end else if (req_below_s) begin
          state_d = MOVE_DOWN;
        end else begin
          state_d = IDLE;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (tmr_done_s) begin
          // Shift one floor, refusing to run off either end.
          if (going_up_s) begin
            floor_d = floor_q[N_FLOORS-1] ? floor_q : {floor_q[N_FLOORS-2:0], 1'b0};
          end else begin
            floor_d = floor_q[0] ? floor_q : {1'b0, floor_q[N_FLOORS-1:1]};
          end
          ahead_s  = going_up_s ? mask_above(floor_d) : mask_below(floor_d);
          behind_s = going_up_s ? mask_below(floor_d) : mask_above(floor_d);
          // A press landing on the arrival edge still stops the car here.
          if (|(floor_d & (pending_q | press_s))) begin
            state_d = DOOR;
          end else if (|(pending_q & ahead_s)) begin
            state_d = state_q;
          end else if (|(pending_q & behind_s)) begin
            state_d = going_up_s ? MOVE_DOWN : MOVE_UP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      DOOR: begin
        if (|(press_s & floor_q)) begin
          door_restart_s = 1'b1;
          state_d        = DOOR;
        end else if (tmr_done_s) begin
          if ((dir_q == UP) && req_above_s) begin
            state_d = MOVE_UP;
          end else if (req_below_s) begin
            state_d = MOVE_DOWN;
          end else if (req_above_s) begin
            state_d = MOVE_UP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DOOR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == MOVE_UP) begin
      dir_d = UP;
    end else if (state_d == MOVE_DOWN) begin
      dir_d = DOWN;
    end else begin
      dir_d = dir_q;
    end

    // Requests at the door floor are absorbed while open and on the entry edge.
    clr_s = '0;
    if (state_q == DOOR) begin
      clr_s = clr_s | floor_q;
    end else begin
      clr_s = clr_s;
    end
    if (state_d == DOOR) begin
      clr_s = clr_s | floor_d;
    end else begin
      clr_s = clr_s;
    end
    pending_d = (pending_q | press_s) & ~clr_s;

    // Reload on every phase entry, each extra floor of travel and door restarts.
    tmr_load_s = (state_d != IDLE) &&
                 ((state_d != state_q) || tmr_done_s || door_restart_s);
    tmr_val_s  = (state_d == DOOR) ? DOOR_LD : TRAVEL_LD;
  end

  // State, position, request and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= UP;
      floor_q   <= N_FLOORS'(1'b1);
      pending_q <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      open_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      up_q      <= (state_d == MOVE_UP);
      down_q    <= (state_d == MOVE_DOWN);
      open_q    <= (state_d == DOOR);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.current_floor = floor_q;
  assign bus.pending       = pending_q;
  assign bus.up            = up_q;
  assign bus.down          = down_q;
  assign bus.open          = open_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_elevator_sched.sv
// tb_elevator_sched: directed table, hand-written corner sequences and a random
// run of elevator_sched, compared against an integer-floor reference model.
module tb_elevator_sched;

  localparam int N = 10;
  localparam int T = 8;
  localparam int D = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_UP   = 1;
  localparam int PH_DN   = 2;
  localparam int PH_DOOR = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  elevator_sched_if #(.N_FLOORS(N)) bus ();

  elevator_sched #(.N_FLOORS(N), .TRAVEL_CYC(T), .DOOR_CYC(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: floor as an integer, requests as a bit array.
  int         m_fl;
  logic [N-1:0] m_pend;
  int         m_ph;
  int         m_left;
  bit         m_up_dir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_above(input logic [N-1:0] p, input int f);
    for (int k = f + 1; k < N; k++) if (p[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input logic [N-1:0] p, input int f);
    for (int k = 0; k < f; k++) if (p[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit rst, input logic [N-1:0] press);
    int old_ph;
    int old_fl;
    logic [N-1:0] p;
    old_ph = m_ph;
    old_fl = m_fl;
    p = m_pend;
    if (rst) begin
      m_fl = 0; m_pend = '0; m_ph = PH_IDLE; m_left = 0; m_up_dir = 1'b1;
      return;
    end
    case (m_ph)
      PH_IDLE: begin
        if (p[m_fl]) begin m_ph = PH_DOOR; m_left = D; end
        else if (any_above(p, m_fl) && any_below(p, m_fl)) begin
          m_ph = m_up_dir ? PH_UP : PH_DN; m_left = T;
        end
        else if (any_above(p, m_fl)) begin m_ph = PH_UP; m_left = T; end
        else if (any_below(p, m_fl)) begin m_ph = PH_DN; m_left = T; end
      end
      PH_UP, PH_DN: begin
        m_left--;
        if (m_left == 0) begin
          m_fl += (m_ph == PH_UP) ? 1 : -1;
          if (p[m_fl] || press[m_fl]) begin m_ph = PH_DOOR; m_left = D; end
          else if ((m_ph == PH_UP) ? any_above(p, m_fl) : any_below(p, m_fl)) m_left = T;
          else if ((m_ph == PH_UP) ? any_below(p, m_fl) : any_above(p, m_fl)) begin
            m_ph = (m_ph == PH_UP) ? PH_DN : PH_UP; m_left = T;
          end
          else m_ph = PH_IDLE;
        end
      end
      default: begin
        if (press[m_fl]) m_left = D;
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_up_dir && any_above(p, m_fl)) m_ph = PH_UP;
            else if (any_below(p, m_fl)) m_ph = PH_DN;
            else if (any_above(p, m_fl)) m_ph = PH_UP;
            else m_ph = PH_IDLE;
            m_left = T;
          end
        end
      end
    endcase
    if (m_ph == PH_UP) m_up_dir = 1'b1;
    else if (m_ph == PH_DN) m_up_dir = 1'b0;
    m_pend = p | press;
    if (old_ph == PH_DOOR) m_pend[old_fl] = 1'b0;
    if (m_ph == PH_DOOR) m_pend[m_fl] = 1'b0;
  endtask

  // One clock: drive inputs, step the model at the edge, sample 1 time unit later.
  task automatic cyc(input logic [N-1:0] bo, input logic [N-1:0] bi, input logic rst);
    logic [N-1:0] ef;
    bus.button_out = bo;
    bus.button_in  = bi;
    rst_n          = ~rst;
    @(posedge clk);
    model_step(rst, bo | bi);
    #1;
    ef = '0;
    ef[m_fl] = 1'b1;
    check("cmd_excl", 32'($countones({bus.up, bus.down, bus.open}) > 1), 32'd0);
    check("m_floor", 32'(bus.current_floor), 32'(ef));
    check("m_pending", 32'(bus.pending), 32'(m_pend));
    check("m_cmds", 32'({bus.up, bus.down, bus.open, bus.busy}),
          32'({m_ph == PH_UP, m_ph == PH_DN, m_ph == PH_DOOR, m_ph != PH_IDLE}));
    bus.button_out = '0;
    bus.button_in  = '0;
    rst_n          = 1'b1;
  endtask

  function automatic logic [N-1:0] fbit(input int f);
    logic [N-1:0] v;
    v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  task automatic wait_open(input int fl, input string name);
    int n;
    n = 0;
    while (bus.open !== 1'b1 && n < 400) begin cyc('0, '0, 1'b0); n++; end
    if (bus.open !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s: door never opened, expected floor %0d", name, fl);
    end else begin
      check(name, 32'(bus.current_floor), 32'(fbit(fl)));
    end
  endtask

  task automatic wait_closed(input string name);
    int n;
    n = 0;
    while (bus.open === 1'b1 && n < 100) begin cyc('0, '0, 1'b0); n++; end
    if (bus.open === 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s: door still open after %0d cycles", name, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin cyc('0, '0, 1'b0); n++; end
    if (bus.busy !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: still busy after %0d cycles", name, n);
    end
  endtask

  typedef struct {
    int           adv;
    logic [N-1:0] bo;
    logic [N-1:0] bi;
    logic         rst;
    logic [N-1:0] floor;
    logic [N-1:0] pend;
    logic         up;
    logic         down;
    logic         open;
    logic         busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.button_out = '0;
    bus.button_in  = '0;
    rst_n          = 1'b0;
    m_fl = 0; m_pend = '0; m_ph = PH_IDLE; m_left = 0; m_up_dir = 1'b1;

    // adv = cycles advanced (inputs held only in the first); then compare.
    tbl[0]  = '{1, 10'h000, 10'h000, 1'b1, 10'h001, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1, 10'h000, 10'h008, 1'b0, 10'h001, 10'h008, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1, 10'h000, 10'h000, 1'b0, 10'h001, 10'h008, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{7, 10'h000, 10'h000, 1'b0, 10'h001, 10'h008, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1, 10'h000, 10'h000, 1'b0, 10'h002, 10'h008, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{8, 10'h000, 10'h000, 1'b0, 10'h004, 10'h008, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{8, 10'h000, 10'h000, 1'b0, 10'h008, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{3, 10'h000, 10'h000, 1'b0, 10'h008, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1, 10'h000, 10'h000, 1'b0, 10'h008, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1, 10'h000, 10'h000, 1'b1, 10'h001, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1, 10'h001, 10'h000, 1'b0, 10'h001, 10'h001, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1, 10'h000, 10'h000, 1'b0, 10'h001, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{3, 10'h000, 10'h000, 1'b0, 10'h001, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1, 10'h000, 10'h000, 1'b0, 10'h001, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0};

    cyc('0, '0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].bo, tbl[i].bi, tbl[i].rst);
      for (int k = 1; k < tbl[i].adv; k++) cyc('0, '0, 1'b0);
      check($sformatf("vec%0d_floor", i), 32'(bus.current_floor), 32'(tbl[i].floor));
      check($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(tbl[i].pend));
      check($sformatf("vec%0d_cmds", i), 32'({bus.up, bus.down, bus.open, bus.busy}),
            32'({tbl[i].up, tbl[i].down, tbl[i].open, tbl[i].busy}));
    end

    // SCAN order: moving 2 -> 7, then 5 ahead and 1 behind are pressed.
    cyc('0, '0, 1'b1);
    cyc('0, fbit(2), 1'b0);
    wait_open(2, "scan_start2");
    wait_idle("scan_idle2");
    cyc('0, fbit(7), 1'b0);
    for (int k = 0; k < 4; k++) cyc('0, '0, 1'b0);
    cyc(fbit(5), fbit(1), 1'b0);
    wait_open(5, "scan_first5");
    wait_closed("scan_close5");
    wait_open(7, "scan_second7");
    wait_closed("scan_close7");
    wait_open(1, "scan_third1");
    wait_closed("scan_close1");
    wait_idle("scan_idle1");

    // Top floor: repeated presses at floor 9 keep the door open.
    cyc('0, fbit(9), 1'b0);
    wait_open(9, "top_arrive9");
    for (int r = 0; r < 3; r++) begin
      cyc('0, '0, 1'b0);
      check("top_open_a", 32'(bus.open), 32'd1);
      cyc('0, '0, 1'b0);
      check("top_open_b", 32'(bus.open), 32'd1);
      cyc('0, fbit(9), 1'b0);
      check("top_open_press", 32'(bus.open), 32'd1);
      check("top_absorbed", 32'(bus.pending), 32'd0);
      check("top_floor", 32'(bus.current_floor), 32'h200);
      check("top_no_up", 32'(bus.up), 32'd0);
    end
    for (int k = 0; k < D - 1; k++) begin
      cyc('0, '0, 1'b0);
      check("top_tail_open", 32'(bus.open), 32'd1);
    end
    cyc('0, '0, 1'b0);
    check("top_closed", 32'({bus.open, bus.busy, bus.up}), 32'd0);

    // Reset while travelling between floors 4 and 5.
    cyc('0, '0, 1'b1);
    cyc('0, fbit(6), 1'b0);
    begin
      int n;
      n = 0;
      while (bus.current_floor !== fbit(4) && n < 200) begin cyc('0, '0, 1'b0); n++; end
      if (bus.current_floor !== fbit(4)) begin
        n_checks++; n_fail++;
        $display("FAIL rst_reach4: floor 0x%0h never became 0x010", bus.current_floor);
      end
    end
    for (int k = 0; k < 3; k++) cyc('0, '0, 1'b0);
    check("rst_mid_up_before", 32'(bus.up), 32'd1);
    cyc('0, '0, 1'b1);
    check("rst_mid_floor", 32'(bus.current_floor), 32'h001);
    check("rst_mid_pending", 32'(bus.pending), 32'd0);
    check("rst_mid_cmds", 32'({bus.up, bus.down, bus.open}), 32'd0);

    // Idle at 4 heading up with calls at 0 and 9: 9 is served first.
    cyc('0, fbit(4), 1'b0);
    wait_open(4, "both_reach4");
    wait_idle("both_idle4");
    cyc(fbit(0), fbit(9), 1'b0);
    wait_open(9, "both_first9");
    wait_closed("both_close9");
    wait_open(0, "both_then0");
    wait_closed("both_close0");

    // Random presses and occasional resets against the reference model.
    cyc('0, '0, 1'b1);
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] bo;
      logic [N-1:0] bi;
      bo = ($urandom_range(0, 9) == 0) ? fbit(int'($urandom_range(0, N - 1))) : '0;
      bi = ($urandom_range(0, 9) == 0) ? fbit(int'($urandom_range(0, N - 1))) : '0;
      cyc(bo, bi, ($urandom_range(0, 1999) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_sched.md
Name: elevator_sched

Overview:
- Main sequencing controller for the elevator car.
- Latches hall and cab button presses into a pending-request register and tracks the car position as a one-hot floor vector.
- Chooses the travel direction using a SCAN policy: keep going the current way while requests remain ahead.
- Times floor-to-floor travel and door-open dwell, and drives the up/down/door commands consumed by the car datapath and door actuator.

Parameters:
- N_FLOORS, 10, number of floors; width of every floor vector (min 2).
- TRAVEL_CYC, 8, cycles spent moving between adjacent floors (>=1).
- DOOR_CYC, 4, cycles the door stays open per stop (>=1).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- button_out, input, N_FLOORS, hall call buttons; bit k = request at floor k; level or pulse, OR-ed into pending.
- button_in, input, N_FLOORS, cab floor-select buttons; same semantics as button_out.
- current_floor, output, N_FLOORS, one-hot car position; bit 0 = ground.
- up, output, 1, car moving up.
- down, output, 1, car moving down.
- open, output, 1, door open command.
- pending, output, N_FLOORS, outstanding requests, registered.
- busy, output, 1, state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, current_floor=1 (floor 0), pending=0, dir=UP, timer=0.
  - up=down=open=busy=0.
  - Reset mid-move or mid-door aborts immediately and returns to floor 0.
- Pending update every cycle: pending <= (pending | button_out | button_in) & ~clr.
  - clr = current_floor while state==DOOR, or on the edge entering DOOR at the arriving floor.
  - Presses for the current floor during DOOR are absorbed, never left pending, and restart the door timer (timer reload to DOOR_CYC).
- Derived signals from registered pending and current_floor: req_here, req_above (any bit above the car), req_below. At the top floor req_above=0; at floor 0 req_below=0.
- States:
  - IDLE: req_here -> DOOR; else req_above and req_below both set -> follow dir; else req_above -> MOVE_UP (dir=UP); else req_below -> MOVE_DOWN (dir=DOWN); else stay.
  - MOVE_UP / MOVE_DOWN: timer counts TRAVEL_CYC cycles. On the edge ending the last cycle, current_floor shifts one position (left for up, right for down). Next state on that same edge:
    - pending bit at the new floor set -> DOOR.
    - else requests still ahead in the same direction -> same state, timer reloaded.
    - else requests behind -> reverse direction.
    - else IDLE.
  - DOOR: open=1 for DOOR_CYC cycles (longer if restarted). On expiry:
    - dir=UP and req_above -> MOVE_UP.
    - else req_below -> MOVE_DOWN (dir=DOWN).
    - else req_above -> MOVE_UP (dir=UP).
    - else IDLE.
- Outputs are Moore and registered: up=(state==MOVE_UP), down=(state==MOVE_DOWN), open=(state==DOOR). up, down and open are mutually exclusive at all times. current_floor never shifts past either end.
- Latency:
  - Request pulse at cycle t -> pending visible at t+1 -> up/down/open asserted at t+2 when the car is idle.
  - Travel across d floors takes d*TRAVEL_CYC cycles of up/down.
- Simultaneous events:
  - Press at the arrival floor on the arrival edge -> picked up by clr; the car stops there.
  - Press behind the car while moving -> served after the current sweep.
- Timer width = clog2(max(TRAVEL_CYC, DOOR_CYC))+1, down-counting, reload on state entry.

Decomposition:
- Package elevator_pkg holds:
  - State enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR} and dir enum {UP, DOWN}.
  - Default floor/timing constants.
  - clog2-based timer-width function.
- One natural sub-module: elev_timer, a loadable down-counter with load value, load strobe and done flag, shared by the travel and door phases.

Test Plan:
- Reset, idle at floor 0, single-cycle pulse button_in[3] -> up=1 from cycle t+2 for 24 cycles; current_floor 0x002, 0x004, 0x008 every 8 cycles; then open=1 for 4 cycles, pending=0, IDLE, busy=0.
- Car idle at floor 0, button_out[0] pulse -> open=1 at t+2 for 4 cycles, no movement, pending[0] never reads 1 after the door opens.
- At floor 2 moving up toward 7, press button_out[5] during travel and button_in[1] -> stops at 5 (door), then 7 (door), then reverses down to 1 (door); order of open pulses is 5, 7, 1.
- At floor 9 (top) with only button_in[9] pressed repeatedly during DOOR -> door timer restarts each press, current_floor stays 0x200, up never asserts.
- rst_n low for one edge while MOVE_UP between floors 4 and 5 -> next cycle current_floor=0x001, pending=0, up=down=open=0.
- Both requests at floors 0 and 9 set while idle at 4 with dir=UP -> serves 9 first, then 0; check up never overlaps down or open.
